byte_stream_pair_source: RTL

Transmitter for paired operand streams. It drives two independent valid/ready byte streams, a and b, each exactly STREAM_LENGTH beats per frame, into the byte stream adder's operand ports. Beat data is an arithmetic pattern (seed plus k*step) latched at frame start. It serves as the bring-up stimulus source and the built-in self-test source for the adder datapath.

---
 rtl/byte_stream_pair_source.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/byte_stream_pair_source.sv
// rtl/byte_stream_pair_source.sv - paired arithmetic-pattern byte stream source
//
// Emits two independent valid/ready streams, a and b, of STREAM_LENGTH beats
// per frame. Beat k of a channel carries seed + k*step (mod 2^DATA_WIDTH), with
// seed and step captured when start is accepted in IDLE.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   start                 frame request, sampled only in IDLE
//   a_seed/a_step         stream a pattern, latched on accepted start
//   b_seed/b_step         stream b pattern, latched on accepted start
//   a_data/a_valid/a_last stream a beat, a_ready from consumer
//   b_data/b_valid/b_last stream b beat, b_ready from consumer
//   a_count/b_count       beats accepted this frame per channel
//   busy                  high in RUN and DONE
//   done                  one-cycle pulse in DONE

module byte_stream_pair_source #(
  parameter  int DATA_WIDTH    = 8,
  parameter  int STREAM_LENGTH = 16,
  localparam int CW            = $clog2(STREAM_LENGTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a_seed,
  input  logic [DATA_WIDTH-1:0] a_step,
  input  logic [DATA_WIDTH-1:0] b_seed,
  input  logic [DATA_WIDTH-1:0] b_step,
  output logic [DATA_WIDTH-1:0] a_data,
  output logic                  a_valid,
  input  logic                  a_ready,
  output logic                  a_last,
  output logic [DATA_WIDTH-1:0] b_data,
  output logic                  b_valid,
  input  logic                  b_ready,
  output logic                  b_last,
  output logic [CW-1:0]         a_count,
  output logic [CW-1:0]         b_count,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(STREAM_LENGTH - 1);
  localparam logic [CW-1:0] FULL     = CW'(STREAM_LENGTH);

  state_t                state;
  // The data registers themselves hold the latched seed at frame start, so
  // only the steps need their own copies.
  logic [DATA_WIDTH-1:0] a_step_q;
  logic [DATA_WIDTH-1:0] b_step_q;

  logic a_hs;
  logic b_hs;
  logic a_fin;
  logic b_fin;

  assign a_hs  = a_valid && a_ready;
  assign b_hs  = b_valid && b_ready;
  // A channel is finished if it already delivered all beats, or its final
  // beat is being accepted on this edge.
  assign a_fin = (a_count == FULL) || (a_hs && a_last);
  assign b_fin = (b_count == FULL) || (b_hs && b_last);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      a_step_q <= '0;
      b_step_q <= '0;
      a_data   <= '0;
      b_data   <= '0;
      a_valid  <= 1'b0;
      b_valid  <= 1'b0;
      a_last   <= 1'b0;
      b_last   <= 1'b0;
      a_count  <= '0;
      b_count  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_step_q <= a_step;
            b_step_q <= b_step;
            a_data   <= a_seed;
            b_data   <= b_seed;
            a_valid  <= 1'b1;
            b_valid  <= 1'b1;
            a_last   <= (STREAM_LENGTH == 1);
            b_last   <= (STREAM_LENGTH == 1);
            a_count  <= '0;
            b_count  <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end

        RUN: begin
          if (a_hs) begin
            a_count <= a_count + 1'b1;
            a_data  <= a_data + a_step_q;
            if (a_last) begin
              a_valid <= 1'b0;
              a_last  <= 1'b0;
            end else begin
              a_last <= ((a_count + 1'b1) == LAST_IDX);
            end
          end

          if (b_hs) begin
            b_count <= b_count + 1'b1;
            b_data  <= b_data + b_step_q;
            if (b_last) begin
              b_valid <= 1'b0;
              b_last  <= 1'b0;
            end else begin
              b_last <= ((b_count + 1'b1) == LAST_IDX);
            end
          end

          if (a_fin && b_fin) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
